traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- T_BASE, 5'd6, reset value of base interval (s).
- T_EXT, 5'd3, reset value of extension interval (s).
- T_YEL, 5'd2, reset value of yellow interval (s).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- sensor  in  1  side-street vehicle present (level).
- walk_request  in  1  pedestrian button (one-cycle pulse).
- reprogram  in  1  load time_value into the selected interval (pulse).
- time_param_sel  in  2  00 base, 01 ext, 10 yellow, 11 no-op.
- time_value  in  5  new interval (s).
- expired  in  1  timer done (level; timer clears it on start).
- start_timer  out  1  one-cycle timer load strobe.
- interval  out  5  seconds to load; valid while start_timer=1.
- main_light  out  3  {red,yellow,green}.
- side_light  out  3  {red,yellow,green}.
- walk_light  out  1  pedestrian walk lamp.
- state_dbg  out  3  current state encoding.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM SHALL use these states and encodings: MAIN_GRN=0, MAIN_YEL=1, WALK=2, SIDE_GRN=3, SIDE_EXT=4, SIDE_YEL=5; codes 6 and 7 SHALL go to MAIN_GRN on the next cycle.
REQ-005 Lights per state SHALL be as follows, with every other light red and walk_light=0 except in WALK:
- main 001 in MAIN_GRN, 010 in MAIN_YEL, 100 otherwise.
- side 001 in SIDE_GRN/SIDE_EXT, 010 in SIDE_YEL, 100 otherwise.
REQ-006 Interval registers base/ext/yel SHALL be 5-bit; a reprogram pulse SHALL load time_value into the selected register; time_value=0 SHALL be stored as 1; sel=11 SHALL change nothing.
REQ-007 A reprogram pulse with sel!=11 SHALL also restart the FSM in MAIN_GRN, with start_timer using the updated value.
REQ-008 On every state entry, including a re-entry of the same state, start_timer SHALL be 1 for exactly one cycle, and interval SHALL equal the new state's duration at that cycle.
- Durations: MAIN_GRN base; MAIN_YEL yel; WALK ext; SIDE_GRN base; SIDE_EXT ext; SIDE_YEL yel.
REQ-009 expired SHALL be ignored in the start_timer cycle and the following cycle (2-cycle blanking).
REQ-010 Transitions on unblanked expired=1 SHALL be as follows; the state SHALL hold otherwise.
- MAIN_GRN: go to MAIN_YEL if sensor or walk_pend, else re-enter MAIN_GRN.
- MAIN_YEL: go to WALK if walk_pend, else SIDE_GRN.
- WALK: go to SIDE_GRN.
- SIDE_GRN: go to SIDE_EXT if sensor, else SIDE_YEL.
- SIDE_EXT: go to SIDE_YEL.
- SIDE_YEL: go to MAIN_GRN.
REQ-011 walk_pend SHALL be set by walk_request and cleared on WALK entry; a request on the entry cycle or during WALK SHALL be dropped.
REQ-012 Transition latency SHALL be: expired sampled at edge N, then new lights and start_timer both visible after edge N+1.
REQ-013 sensor and walk_pend SHALL be sampled at the same edge as expired.
REQ-014 When reprogram and expired coincide, reprogram SHALL win.

Reset
REQ-015 While reset=1, outputs SHALL be: state MAIN_GRN, main_light=001, side_light=100, walk_light=0, start_timer=0, interval=0, walk_pend=0, and registers base/ext/yel reloaded from the parameters.
REQ-016 In the first cycle after reset deasserts, start_timer=1 and interval=T_BASE; reset mid-state SHALL abort immediately with no yellow phase.

Verification
REQ-017 Reset, then expired with sensor=0 and no walk: start_timer pulses with interval=6 and the state stays MAIN_GRN (state_dbg=0).
REQ-018 sensor=1 held, expired at each phase: sequence 0,1,3,4,5,0 with intervals 6,2,6,3,2,6; lights match REQ-005.
REQ-019 walk_request pulse during MAIN_GRN, sensor=0: walk_light=1 only in WALK with interval=3; a second request during WALK leaves walk_pend=0 afterwards.
REQ-020 reprogram with sel=00, value=0 while in SIDE_GRN: the state goes to MAIN_GRN, interval=1 on start_timer; reprogram coinciding with expired is handled as reprogram.
REQ-021 expired held high across the start_timer cycle and the next one: no transition; a transition occurs only on the third cycle.
REQ-022 Force state_dbg to 6 via a bench-only hook: the state goes to MAIN_GRN and start_timer pulses on the next cycle.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Traffic light controller for a main/side street intersection with a
// pedestrian phase. The controller drives an external countdown timer
// through a one-cycle load strobe and reacts to the timer's level
// 'expired' flag.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   sensor                side-street vehicle present (level)
//   walk_request          pedestrian button (one-cycle pulse)
//   reprogram             load time_value into the interval picked by time_param_sel
//   time_param_sel[1:0]   00 base, 01 ext, 10 yellow, 11 no-op
//   time_value[4:0]       new interval in seconds (0 is stored as 1)
//   expired               timer done (level)
//   start_timer           one-cycle timer load strobe
//   interval[4:0]         seconds to load, valid while start_timer=1
//   main_light[2:0]       {red,yellow,green} for the main street
//   side_light[2:0]       {red,yellow,green} for the side street
//   walk_light            pedestrian walk lamp
//   state_dbg[2:0]        current state encoding
module traffic_light_ctrl #(
  parameter logic [4:0] T_BASE = 5'd6,
  parameter logic [4:0] T_EXT  = 5'd3,
  parameter logic [4:0] T_YEL  = 5'd2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [4:0] time_value,
  input  logic       expired,
  output logic       start_timer,
  output logic [4:0] interval,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    WALK     = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_EXT = 3'd4,
    SIDE_YEL = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [1:0] BLANK_CYCLES = 2'd2;

  // Raw state bits are kept separately so illegal codes 6/7 stay observable.
  logic [2:0] state_r;
  state_t     state;
  assign state     = state_t'(state_r);
  assign state_dbg = state_r;

  logic [4:0] t_base;
  logic [4:0] t_ext;
  logic [4:0] t_yel;
  logic       walk_pend;
  // A decided transition is applied one edge later (expired -> lights latency).
  logic       trans_pend;
  state_t     trans_target;
  logic [1:0] blank_cnt;

  state_t     next_state_c;
  logic       load_c;
  logic [4:0] load_value_c;
  logic [4:0] target_dur_c;

  function automatic logic [2:0] main_lamp(input state_t s);
    case (s)
      MAIN_GRN: main_lamp = LAMP_GRN;
      MAIN_YEL: main_lamp = LAMP_YEL;
      default:  main_lamp = LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input state_t s);
    case (s)
      SIDE_GRN, SIDE_EXT: side_lamp = LAMP_GRN;
      SIDE_YEL:           side_lamp = LAMP_YEL;
      default:            side_lamp = LAMP_RED;
    endcase
  endfunction

  // Reprogram request decode; a zero interval would stall the timer.
  always_comb begin
    load_c       = reprogram && (time_param_sel != 2'b11);
    load_value_c = (time_value == 5'd0) ? 5'd1 : time_value;
  end

  // Duration of the state about to be entered.
  always_comb begin
    case (trans_target)
      MAIN_YEL, SIDE_YEL: target_dur_c = t_yel;
      WALK, SIDE_EXT:     target_dur_c = t_ext;
      default:            target_dur_c = t_base;
    endcase
  end

  // Successor state on an unblanked expiry.
  always_comb begin
    next_state_c = MAIN_GRN;
    case (state)
      MAIN_GRN: next_state_c = (sensor || walk_pend) ? MAIN_YEL : MAIN_GRN;
      MAIN_YEL: next_state_c = walk_pend ? WALK : SIDE_GRN;
      WALK:     next_state_c = SIDE_GRN;
      SIDE_GRN: next_state_c = sensor ? SIDE_EXT : SIDE_YEL;
      SIDE_EXT: next_state_c = SIDE_YEL;
      SIDE_YEL: next_state_c = MAIN_GRN;
      default:  next_state_c = MAIN_GRN;
    endcase
  end

  // FSM, interval registers and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= 3'(MAIN_GRN);
      main_light   <= LAMP_GRN;
      side_light   <= LAMP_RED;
      walk_light   <= 1'b0;
      start_timer  <= 1'b0;
      interval     <= 5'd0;
      walk_pend    <= 1'b0;
      t_base       <= T_BASE;
      t_ext        <= T_EXT;
      t_yel        <= T_YEL;
      // Entry into MAIN_GRN is announced on the first cycle out of reset.
      trans_pend   <= 1'b1;
      trans_target <= MAIN_GRN;
      blank_cnt    <= 2'd0;
    end else begin
      start_timer <= 1'b0;

      if (walk_request && (state != WALK)) begin
        walk_pend <= 1'b1;
      end

      if (load_c) begin
        case (time_param_sel)
          2'b00:   t_base <= load_value_c;
          2'b01:   t_ext  <= load_value_c;
          default: t_yel  <= load_value_c;
        endcase
      end

      if (load_c) begin
        // Restart wins over any pending transition or expiry.
        trans_pend   <= 1'b1;
        trans_target <= MAIN_GRN;
      end else if (state_r > 3'(SIDE_YEL)) begin
        // Illegal code: recover straight into MAIN_GRN.
        state_r     <= 3'(MAIN_GRN);
        main_light  <= LAMP_GRN;
        side_light  <= LAMP_RED;
        walk_light  <= 1'b0;
        start_timer <= 1'b1;
        interval    <= t_base;
        blank_cnt   <= BLANK_CYCLES;
        trans_pend  <= 1'b0;
      end else if (trans_pend) begin
        state_r     <= 3'(trans_target);
        main_light  <= main_lamp(trans_target);
        side_light  <= side_lamp(trans_target);
        walk_light  <= (trans_target == WALK);
        start_timer <= 1'b1;
        interval    <= target_dur_c;
        blank_cnt   <= BLANK_CYCLES;
        trans_pend  <= 1'b0;
        if (trans_target == WALK) begin
          walk_pend <= 1'b0;
        end
      end else if (blank_cnt != 2'd0) begin
        // Timer may still show the previous expiry right after a load.
        blank_cnt <= blank_cnt - 2'd1;
      end else if (expired) begin
        trans_pend   <= 1'b1;
        trans_target <= next_state_c;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       sensor;
  logic       walk_request;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [4:0] time_value;
  logic       expired;
  logic       start_timer;
  logic [4:0] interval;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_light;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] obs;
  assign obs = {state_dbg, start_timer, interval, main_light, side_light, walk_light};

  traffic_light_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .sensor         (sensor),
    .walk_request   (walk_request),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired        (expired),
    .start_timer    (start_timer),
    .interval       (interval),
    .main_light     (main_light),
    .side_light     (side_light),
    .walk_light     (walk_light),
    .state_dbg      (state_dbg)
  );

  always #5 clock = ~clock;

  // Expected {state, start_timer, interval, main, side, walk} for a state.
  function automatic logic [15:0] exp_vec(input int s, input logic st, input logic [4:0] iv);
    logic [2:0] m;
    logic [2:0] sd;
    m  = (s == 0) ? 3'b001 : (s == 1) ? 3'b010 : 3'b100;
    sd = (s == 3 || s == 4) ? 3'b001 : (s == 5) ? 3'b010 : 3'b100;
    return {3'(s), st, iv, m, sd, (s == 2)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called in a start_timer cycle: let blanking lapse, pulse expired, reach the entry cycle.
  task automatic step(input logic sens);
    sensor  = sens;
    expired = 1'b0;
    tick();
    tick();
    expired = 1'b1;
    tick();
    expired = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b0, 5'd0)) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, exp_vec(0, 1'b0, 5'd0)); end
    n_checks++; if ({dut.walk_pend, dut.t_base, dut.t_ext, dut.t_yel} !== {1'b0, 5'd6, 5'd3, 5'd2}) begin n_fail++; $display("FAIL reset_regs: got %h want %h", {dut.walk_pend, dut.t_base, dut.t_ext, dut.t_yel}, {1'b0, 5'd6, 5'd3, 5'd2}); end
    reset = 1'b0;
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b1, 5'd6)) begin n_fail++; $display("FAIL reset_release: got %h want %h", obs, exp_vec(0, 1'b1, 5'd6)); end
  endtask

  task automatic test_no_traffic();
    sensor = 1'b0;
    tick();
    tick();
    expired = 1'b1;
    tick();
    expired = 1'b0;
    n_checks++; if (obs !== exp_vec(0, 1'b0, 5'd6)) begin n_fail++; $display("FAIL latency_gap: got %h want %h", obs, exp_vec(0, 1'b0, 5'd6)); end
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b1, 5'd6)) begin n_fail++; $display("FAIL main_reenter: got %h want %h", obs, exp_vec(0, 1'b1, 5'd6)); end
  endtask

  task automatic test_sensor_cycle();
    int          st[5] = '{1, 3, 4, 5, 0};
    logic [4:0]  iv[5] = '{5'd2, 5'd6, 5'd3, 5'd2, 5'd6};
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      n_checks++; if (obs !== exp_vec(st[i], 1'b1, iv[i])) begin n_fail++; $display("FAIL sensor_seq[%0d]: got %h want %h", i, obs, exp_vec(st[i], 1'b1, iv[i])); end
    end
    sensor = 1'b0;
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b0, 5'd6)) begin n_fail++; $display("FAIL strobe_width: got %h want %h", obs, exp_vec(0, 1'b0, 5'd6)); end
  endtask

  task automatic test_walk();
    walk_request = 1'b1;
    tick();
    walk_request = 1'b0;
    n_checks++; if (dut.walk_pend !== 1'b1) begin n_fail++; $display("FAIL walk_pend_set: got %b want 1", dut.walk_pend); end
    step(1'b0);
    n_checks++; if (obs !== exp_vec(1, 1'b1, 5'd2)) begin n_fail++; $display("FAIL walk_main_yel: got %h want %h", obs, exp_vec(1, 1'b1, 5'd2)); end
    step(1'b0);
    n_checks++; if (obs !== exp_vec(2, 1'b1, 5'd3)) begin n_fail++; $display("FAIL walk_enter: got %h want %h", obs, exp_vec(2, 1'b1, 5'd3)); end
    n_checks++; if (dut.walk_pend !== 1'b0) begin n_fail++; $display("FAIL walk_pend_clr: got %b want 0", dut.walk_pend); end
    walk_request = 1'b1;
    tick();
    tick();
    walk_request = 1'b0;
    n_checks++; if (dut.walk_pend !== 1'b0) begin n_fail++; $display("FAIL walk_drop: got %b want 0", dut.walk_pend); end
    step(1'b0);
    n_checks++; if (obs !== exp_vec(3, 1'b1, 5'd6)) begin n_fail++; $display("FAIL walk_to_side: got %h want %h", obs, exp_vec(3, 1'b1, 5'd6)); end
    n_checks++; if (dut.walk_pend !== 1'b0) begin n_fail++; $display("FAIL walk_pend_after: got %b want 0", dut.walk_pend); end
    step(1'b0);
    n_checks++; if (obs !== exp_vec(5, 1'b1, 5'd2)) begin n_fail++; $display("FAIL side_yel: got %h want %h", obs, exp_vec(5, 1'b1, 5'd2)); end
    step(1'b0);
    n_checks++; if (obs !== exp_vec(0, 1'b1, 5'd6)) begin n_fail++; $display("FAIL back_main: got %h want %h", obs, exp_vec(0, 1'b1, 5'd6)); end
  endtask

  task automatic test_reprogram();
    step(1'b1);
    step(1'b1);
    sensor = 1'b0;
    n_checks++; if (obs !== exp_vec(3, 1'b1, 5'd6)) begin n_fail++; $display("FAIL reach_side_grn: got %h want %h", obs, exp_vec(3, 1'b1, 5'd6)); end
    reprogram = 1'b1; time_param_sel = 2'b00; time_value = 5'd0;
    tick();
    reprogram = 1'b0;
    n_checks++; if (obs !== exp_vec(3, 1'b0, 5'd6)) begin n_fail++; $display("FAIL reprog_gap: got %h want %h", obs, exp_vec(3, 1'b0, 5'd6)); end
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b1, 5'd1)) begin n_fail++; $display("FAIL reprog_zero: got %h want %h", obs, exp_vec(0, 1'b1, 5'd1)); end
    // Reprogram and an unblanked expiry with sensor=1 on the same edge.
    tick();
    tick();
    sensor = 1'b1; expired = 1'b1;
    reprogram = 1'b1; time_param_sel = 2'b00; time_value = 5'd6;
    tick();
    sensor = 1'b0; expired = 1'b0; reprogram = 1'b0;
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b1, 5'd6)) begin n_fail++; $display("FAIL reprog_vs_expired: got %h want %h", obs, exp_vec(0, 1'b1, 5'd6)); end
    reprogram = 1'b1; time_param_sel = 2'b11; time_value = 5'd9;
    tick();
    reprogram = 1'b0;
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b0, 5'd6)) begin n_fail++; $display("FAIL reprog_noop: got %h want %h", obs, exp_vec(0, 1'b0, 5'd6)); end
    n_checks++; if ({dut.t_base, dut.t_ext, dut.t_yel} !== {5'd6, 5'd3, 5'd2}) begin n_fail++; $display("FAIL noop_regs: got %h want %h", {dut.t_base, dut.t_ext, dut.t_yel}, {5'd6, 5'd3, 5'd2}); end
    reprogram = 1'b1; time_param_sel = 2'b10; time_value = 5'd5;
    tick();
    reprogram = 1'b0;
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b1, 5'd6)) begin n_fail++; $display("FAIL reprog_yel_restart: got %h want %h", obs, exp_vec(0, 1'b1, 5'd6)); end
    step(1'b1);
    n_checks++; if (obs !== exp_vec(1, 1'b1, 5'd5)) begin n_fail++; $display("FAIL new_yel_used: got %h want %h", obs, exp_vec(1, 1'b1, 5'd5)); end
    sensor = 1'b0;
    reprogram = 1'b1; time_param_sel = 2'b10; time_value = 5'd2;
    tick();
    reprogram = 1'b0;
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b1, 5'd6)) begin n_fail++; $display("FAIL reprog_restore: got %h want %h", obs, exp_vec(0, 1'b1, 5'd6)); end
  endtask

  task automatic test_blanking();
    sensor = 1'b1; expired = 1'b1;
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b0, 5'd6)) begin n_fail++; $display("FAIL blank_cycle1: got %h want %h", obs, exp_vec(0, 1'b0, 5'd6)); end
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b0, 5'd6)) begin n_fail++; $display("FAIL blank_cycle2: got %h want %h", obs, exp_vec(0, 1'b0, 5'd6)); end
    tick();
    expired = 1'b0;
    n_checks++; if (obs !== exp_vec(0, 1'b0, 5'd6)) begin n_fail++; $display("FAIL blank_sampled: got %h want %h", obs, exp_vec(0, 1'b0, 5'd6)); end
    tick();
    sensor = 1'b0;
    n_checks++; if (obs !== exp_vec(1, 1'b1, 5'd2)) begin n_fail++; $display("FAIL blank_transition: got %h want %h", obs, exp_vec(1, 1'b1, 5'd2)); end
  endtask

  task automatic test_reset_mid();
    reprogram = 1'b1; time_param_sel = 2'b01; time_value = 5'd9;
    tick();
    reprogram = 1'b0;
    tick();
    step(1'b1);
    sensor = 1'b0;
    n_checks++; if (obs !== exp_vec(1, 1'b1, 5'd2)) begin n_fail++; $display("FAIL mid_main_yel: got %h want %h", obs, exp_vec(1, 1'b1, 5'd2)); end
    reset = 1'b1;
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b0, 5'd0)) begin n_fail++; $display("FAIL mid_reset_out: got %h want %h", obs, exp_vec(0, 1'b0, 5'd0)); end
    n_checks++; if (dut.t_ext !== 5'd3) begin n_fail++; $display("FAIL mid_reset_ext: got %0d want 3", dut.t_ext); end
    reset = 1'b0;
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b1, 5'd6)) begin n_fail++; $display("FAIL mid_reset_release: got %h want %h", obs, exp_vec(0, 1'b1, 5'd6)); end
  endtask

  task automatic test_bad_state();
    tick();
    tick();
    tick();
    dut.state_r <= 3'd6;
    #1;
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b1, 5'd6)) begin n_fail++; $display("FAIL bad_state_recover: got %h want %h", obs, exp_vec(0, 1'b1, 5'd6)); end
    tick();
    n_checks++; if (obs !== exp_vec(0, 1'b0, 5'd6)) begin n_fail++; $display("FAIL bad_state_strobe: got %h want %h", obs, exp_vec(0, 1'b0, 5'd6)); end
  endtask

  initial begin
    reset = 1'b1; sensor = 1'b0; walk_request = 1'b0; reprogram = 1'b0;
    time_param_sel = 2'b00; time_value = 5'd0; expired = 1'b0;
    test_reset();
    test_no_traffic();
    test_sensor_cycle();
    test_walk();
    test_reprogram();
    test_blanking();
    test_reset_mid();
    test_bad_state();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
